// File: rtl/pipeline_trace_buffer_if.sv
// Read port of the pipeline trace buffer: valid/ready handshake plus head record.
// Record width is 59 bits when TRACE_TIMESTAMP_EN is defined, 43 bits otherwise.
interface pipeline_trace_buffer_if #(
`ifdef TRACE_TIMESTAMP_EN
  parameter int REC_W = 59
`else
  parameter int REC_W = 43
`endif
);
  logic             rd_valid;
  logic             rd_ready;
  logic [REC_W-1:0] rd_data;

  modport master (output rd_valid, output rd_data, input rd_ready);
  modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/pipeline_trace_buffer.sv
// Trace capture of CPU hazard flags, control and data words into a drainable FIFO.
// Optional TRACE_TIMESTAMP_EN prepends a 16-bit arm-relative cycle stamp to each record.
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | waiting for i_arm
// ST_ARMED   | waiting for the first cycle with i_h1 | i_h2 (trigger)
// ST_CAPTURE | one sample per cycle until N_CAPTURE samples taken
// ST_DONE    | window complete; back to idle once the FIFO is empty
module pipeline_trace_buffer #(
  parameter int DEPTH     = 16,
  parameter int N_CAPTURE = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_h1,
  input  logic                      i_h2,
  input  logic [8:0]                i_control,
  input  logic [31:0]               i_data,
  input  logic                      i_arm,
  input  logic                      i_clr_cnt,
  pipeline_trace_buffer_if.master   rd,
  output logic [$clog2(DEPTH):0]    o_count,
  output logic                      o_full,
  output logic [1:0]                o_state,
  output logic                      o_overflow,
  output logic [15:0]               o_h1_cnt,
  output logic [15:0]               o_h2_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef TRACE_TIMESTAMP_EN
  localparam int REC_W = 59;
`else
  localparam int REC_W = 43;
`endif
  localparam logic [15:0] CAP_REM = 16'(N_CAPTURE - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ARMED   = 2'b01,
    ST_CAPTURE = 2'b10,
    ST_DONE    = 2'b11
  } state_t;

  state_t           state;
  logic [REC_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [15:0]      cap_left;
  logic [REC_W-1:0] sample;
  logic             trigger;
  logic             take;
  logic             push;
  logic             pop;
`ifdef TRACE_TIMESTAMP_EN
  logic [15:0]      ts_cnt;
`endif

  always_comb begin
    trigger     = (state == ST_ARMED) && (i_h1 || i_h2);
    take        = trigger || (state == ST_CAPTURE);
    // fullness is judged on the registered count, so a same-cycle pop never frees room
    push        = take && !o_full;
    pop         = rd.rd_valid && rd.rd_ready;
    o_full      = (o_count == CW'(DEPTH));
    rd.rd_valid = (o_count != '0);
    rd.rd_data  = rd.rd_valid ? mem[rd_ptr] : '0;
    o_state     = state;
`ifdef TRACE_TIMESTAMP_EN
    // stamp is the counter value as of the sampling edge
    sample      = {ts_cnt + 16'd1, i_h1, i_h2, i_control, i_data};
`else
    sample      = {i_h1, i_h2, i_control, i_data};
`endif
  end

  always_ff @(posedge i_clk) begin
    if (push && !i_rst) begin
      mem[wr_ptr] <= sample;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      cap_left   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_count    <= '0;
      o_overflow <= 1'b0;
      o_h1_cnt   <= '0;
      o_h2_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_arm) state <= ST_ARMED;
        end
        ST_ARMED: begin
          if (trigger) begin
            state    <= (CAP_REM == 16'd0) ? ST_DONE : ST_CAPTURE;
            cap_left <= CAP_REM;
          end
        end
        ST_CAPTURE: begin
          if (cap_left == 16'd1) state <= ST_DONE;
          cap_left <= cap_left - 16'd1;
        end
        ST_DONE: begin
          if (o_count == '0) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   o_count <= o_count + 1'b1;
        2'b01:   o_count <= o_count - 1'b1;
        default: o_count <= o_count;
      endcase

      if (i_clr_cnt)          o_overflow <= 1'b0;
      else if (take && o_full) o_overflow <= 1'b1;

      if (i_clr_cnt)                       o_h1_cnt <= '0;
      else if (i_h1 && o_h1_cnt != 16'hFFFF) o_h1_cnt <= o_h1_cnt + 16'd1;

      if (i_clr_cnt)                       o_h2_cnt <= '0;
      else if (i_h2 && o_h2_cnt != 16'hFFFF) o_h2_cnt <= o_h2_cnt + 16'd1;
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  always_ff @(posedge i_clk) begin
    if (i_rst)                           ts_cnt <= '0;
    else if (state == ST_IDLE && i_arm)  ts_cnt <= '0;
    else                                 ts_cnt <= ts_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// Directed bench for pipeline_trace_buffer: two instances (4- and 20-sample windows).
// Timestamp checks are compiled in only when TRACE_TIMESTAMP_EN is defined.
module tb_pipeline_trace_buffer;
`ifdef TRACE_TIMESTAMP_EN
  localparam int RW = 59;
`else
  localparam int RW = 43;
`endif

  logic        clk;
  logic        rst;
  logic        h1, h2;
  logic [8:0]  control;
  logic [31:0] data;
  logic        clr_cnt;
  logic        arm_a, arm_b;

  logic [4:0]  count_a, count_b;
  logic        full_a, full_b;
  logic [1:0]  state_a, state_b;
  logic        ovf_a, ovf_b;
  logic [15:0] h1_cnt_a, h2_cnt_a, h1_cnt_b, h2_cnt_b;

  int n_total = 0;
  int n_bad   = 0;

  pipeline_trace_buffer_if #(.REC_W(RW)) ifa ();
  pipeline_trace_buffer_if #(.REC_W(RW)) ifb ();

  pipeline_trace_buffer #(.DEPTH(16), .N_CAPTURE(4)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_h1(h1), .i_h2(h2), .i_control(control), .i_data(data),
    .i_arm(arm_a), .i_clr_cnt(clr_cnt), .rd(ifa),
    .o_count(count_a), .o_full(full_a), .o_state(state_a), .o_overflow(ovf_a),
    .o_h1_cnt(h1_cnt_a), .o_h2_cnt(h2_cnt_a)
  );

  pipeline_trace_buffer #(.DEPTH(16), .N_CAPTURE(20)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_h1(h1), .i_h2(h2), .i_control(control), .i_data(data),
    .i_arm(arm_b), .i_clr_cnt(clr_cnt), .rd(ifb),
    .o_count(count_b), .o_full(full_b), .o_state(state_b), .o_overflow(ovf_b),
    .o_h1_cnt(h1_cnt_b), .o_h2_cnt(h2_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [42:0] rec(input logic a, input logic b,
                                      input logic [8:0] c, input logic [31:0] d);
    return {a, b, c, d};
  endfunction

  logic [42:0] exp_a [4];

  initial begin
    rst = 1'b1; h1 = 0; h2 = 0; control = '0; data = '0; clr_cnt = 0;
    arm_a = 0; arm_b = 0; ifa.rd_ready = 0; ifb.rd_ready = 0;
    step();
    rst = 1'b0;
    chk("rst_state", state_a, 2'b00);
    chk("rst_count", count_a, 0);
    chk("rst_valid", ifa.rd_valid, 0);
    chk("rst_data", ifa.rd_data, 0);
    chk("rst_full", full_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_h1cnt", h1_cnt_a, 0);

    // short window: armed for 10 quiet cycles, then trigger on h1
    arm_a = 1; step(); arm_a = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("armed_wait", state_a, 2'b01);
    end
    exp_a[0] = rec(1'b1, 1'b0, 9'h1A5, 32'hDEAD_BEEF);
    for (int i = 1; i < 4; i++) exp_a[i] = rec(1'b0, 1'b0, 9'(9'h010 + i), 32'h1000_0000 + i);
    h1 = 1; control = 9'h1A5; data = 32'hDEAD_BEEF;
    step();
    chk("trig_state", state_a, 2'b10);
    chk("trig_count", count_a, 1);
    for (int i = 1; i < 4; i++) begin
      h1 = 0; control = 9'(9'h010 + i); data = 32'h1000_0000 + i;
      step();
    end
    chk("win4_state", state_a, 2'b11);
    chk("win4_count", count_a, 4);
    chk("win4_head", ifa.rd_data[42:0], exp_a[0]);
    chk("win4_h1cnt", h1_cnt_a, 1);
    ifa.rd_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("win4_drain", ifa.rd_data[42:0], exp_a[i]);
      step();
    end
    ifa.rd_ready = 0;
    chk("win4_empty_cnt", count_a, 0);
    chk("win4_empty_data", ifa.rd_data, 0);
    chk("win4_done_hold", state_a, 2'b11);
    step();
    chk("win4_idle", state_a, 2'b00);

    // 20-sample window into a 16-deep FIFO with no reader: 4 drops
    arm_b = 1; step(); arm_b = 0;
    for (int i = 0; i < 20; i++) begin
      h1 = 0; h2 = (i == 0); control = 9'(i); data = 32'hB000_0000 + i;
      step();
      if (i == 15) begin
        chk("ovf_full_at16", full_b, 1);
        chk("ovf_not_yet", ovf_b, 0);
      end
      if (i == 16) chk("ovf_first_drop", ovf_b, 1);
    end
    h2 = 0;
    chk("ovf_state", state_b, 2'b11);
    chk("ovf_count", count_b, 16);
    chk("ovf_full", full_b, 1);
    chk("ovf_flag", ovf_b, 1);
    ifb.rd_ready = 1;
    for (int i = 0; i < 16; i++) begin
      chk("ovf_drain", ifb.rd_data[42:0], rec(1'b0, i == 0, 9'(i), 32'hB000_0000 + i));
      step();
    end
    ifb.rd_ready = 0;
    chk("ovf_empty", count_b, 0);
    chk("ovf_sticky", ovf_b, 1);
    step();
    chk("ovf_idle", state_b, 2'b00);

    clr_cnt = 1; step(); clr_cnt = 0;
    chk("clr_ovf", ovf_b, 0);
    chk("clr_h2cnt", h2_cnt_b, 0);

    // 20-sample window with a reader always ready: occupancy stays at 1
    ifb.rd_ready = 1;
    arm_b = 1; step(); arm_b = 0;
    for (int i = 0; i < 20; i++) begin
      h1 = (i == 0); control = 9'h100 | 9'(i); data = 32'hC000_0000 + i;
      step();
      chk("flow_count", count_b, 1);
      chk("flow_head", ifb.rd_data[42:0], rec(i == 0, 1'b0, 9'h100 | 9'(i), 32'hC000_0000 + i));
    end
    h1 = 0;
    chk("flow_done", state_b, 2'b11);
    step();
    chk("flow_empty", count_b, 0);
    chk("flow_done_hold", state_b, 2'b11);
    step();
    chk("flow_idle", state_b, 2'b00);
    chk("flow_no_ovf", ovf_b, 0);
    ifb.rd_ready = 0;

`ifdef TRACE_TIMESTAMP_EN
    // trigger lands on the third edge after the arm-accepting edge
    arm_a = 1; step(); arm_a = 0;
    step();
    step();
    h1 = 1; control = '0; data = '0;
    step();
    h1 = 0;
    step(); step(); step();
    chk("ts_done", state_a, 2'b11);
    ifa.rd_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("ts_value", ifa.rd_data[58:43], 16'(3 + i));
      step();
    end
    ifa.rd_ready = 0;
    step();
    chk("ts_idle", state_a, 2'b00);
`endif

    // saturation of both hazard counters, then clear with a flag still high
    clr_cnt = 1; step(); clr_cnt = 0;
    chk("sat_clr0", h1_cnt_a, 0);
    h1 = 1; h2 = 1;
    repeat (65534) step();
    chk("sat_h1_fffe", h1_cnt_a, 16'hFFFE);
    chk("sat_h2_fffe", h2_cnt_a, 16'hFFFE);
    step();
    chk("sat_h1_ffff", h1_cnt_a, 16'hFFFF);
    repeat (4465) step();
    chk("sat_h1_hold", h1_cnt_a, 16'hFFFF);
    chk("sat_h2_hold", h2_cnt_a, 16'hFFFF);
    chk("sat_b_h1", h1_cnt_b, 16'hFFFF);
    clr_cnt = 1; step(); clr_cnt = 0;
    chk("clr_pri_h1", h1_cnt_a, 0);
    chk("clr_pri_h2", h2_cnt_a, 0);
    h2 = 0;
    step();
    chk("post_clr_h1", h1_cnt_a, 1);
    chk("post_clr_h2", h2_cnt_a, 0);
    h1 = 0;

    // reset in the middle of a capture with five records buffered
    arm_b = 1; step(); arm_b = 0;
    h1 = 1; control = 9'h0AA; data = 32'h5555_0000;
    step();
    h1 = 0;
    repeat (4) step();
    chk("mid_state", state_b, 2'b10);
    chk("mid_count", count_b, 5);
    rst = 1; step(); rst = 0;
    chk("mrst_state", state_b, 2'b00);
    chk("mrst_count", count_b, 0);
    chk("mrst_valid", ifb.rd_valid, 0);
    chk("mrst_data", ifb.rd_data, 0);
    chk("mrst_full", full_b, 0);
    chk("mrst_ovf", ovf_b, 0);
    chk("mrst_h1cnt", h1_cnt_b, 0);
    chk("mrst_h2cnt", h2_cnt_b, 0);
    step();
    chk("mrst_stay_idle", state_b, 2'b00);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/pipeline_trace_buffer.md
# pipeline_trace_buffer

Trace-capture stage downstream of the hazard-aware pipeline CPU. Each cycle it samples the CPU's two hazard flags, 9-bit control word and 32-bit data word, counts hazard events, and, once armed, triggers on the first hazard. It then records a fixed-length window of samples into a FIFO, which is drained over a valid/ready read port for debug readout.

## Interface
Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥4.
- N_CAPTURE, 16, samples per capture window, 1..65535; samples may exceed DEPTH if the reader drains concurrently.

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_h1  input  1  hazard flag 1 from CPU.
- i_h2  input  1  hazard flag 2 from CPU.
- i_control  input  9  CPU control word.
- i_data  input  32  CPU data word.
- i_arm  input  1  one-cycle pulse; arms capture, honoured only in IDLE.
- i_clr_cnt  input  1  clears hazard counters and o_overflow.
- i_rd_ready  input  1  reader accepts head record.
- o_rd_valid  output  1  head record available (FIFO non-empty).
- o_rd_data  output  43 (59 with timestamp)  head record; zero when empty.
- o_count  output  log2(DEPTH)+1  FIFO occupancy.
- o_full  output  1  o_count == DEPTH.
- o_state  output  2  00 IDLE, 01 ARMED, 10 CAPTURE, 11 DONE.
- o_overflow  output  1  sticky: a capture sample was dropped.
- o_h1_cnt  output  16  saturating count of cycles with i_h1=1.
- o_h2_cnt  output  16  saturating count of cycles with i_h2=1.

## Operation
- Record format: [42]=h1, [41]=h2, [40:32]=control, [31:0]=data.
- FSM:
  - IDLE→ARMED on i_arm.
  - ARMED→CAPTURE on the first cycle with i_h1|i_h2; that cycle's sample is record 0.
  - In CAPTURE, every cycle is one sample. After sample N_CAPTURE has been taken, go to DONE. With N_CAPTURE=1, the trigger cycle goes straight to DONE.
  - DONE→IDLE in the cycle the FIFO is observed empty.
  - i_arm is ignored outside IDLE.
- Sample write: enqueue if FIFO not full at the start of the cycle. Otherwise drop it, set o_overflow, and still count it toward N_CAPTURE. A pop in the same cycle does not free space for that cycle's write.
- Read: a pop occurs when o_rd_valid & i_rd_ready. o_rd_data shows mem[rd_ptr] and advances after the pop edge. Pointers wrap modulo DEPTH. Simultaneous push and pop leaves o_count unchanged.
- Counters:
  - o_h1_cnt and o_h2_cnt increment every cycle their flag is high, in any state, and saturate at 0xFFFF.
  - If both flags are high, both increment.
  - i_clr_cnt has priority over increment that cycle and also clears o_overflow.
- Reset clears everything: state IDLE, pointers and o_count 0, o_rd_valid 0, o_rd_data 0, o_full 0, o_overflow 0, counters 0, timestamp 0. FIFO contents are discarded; a capture in progress is abandoned.

## Timing
- Write latency: a sample taken at edge k is visible at o_rd_data/o_rd_valid after edge k (cycle k+1). No read-during-write bypass to the head.
- Trigger: hazard seen on edge k moves o_state to 10 after edge k, and record 0 is written on edge k.
- DONE is entered on the edge that takes the last sample.
- Counter update and FIFO write are one edge after the input is presented. All outputs are registered or derived from registers; no combinational input-to-output path.
- o_rd_valid may stay high across back-to-back pops; one record per cycle maximum.

## Configuration
- TRACE_TIMESTAMP_EN defined:
  - A 16-bit cycle counter clears on the edge that accepts i_arm and wraps at 0xFFFF.
  - Each record gains [58:43]=timestamp, so the record on the arm-accept+1 cycle carries 1.
  - o_rd_data is 59 bits.
- Not defined: no timestamp logic; o_rd_data is 43 bits.

## Test plan
- Reset mid-capture (state 10, o_count=5), assert i_rst one cycle → all outputs zero, o_state=00, o_rd_valid=0.
- Arm, hold hazards low 10 cycles, then i_h1=1 with control=9'h1A5, data=32'hDEAD_BEEF, N_CAPTURE=4, reader idle → o_state=01 for 10 cycles, then four records. Head record = {1,0,9'h1A5,32'hDEADBEEF}. o_count=4, o_state=11.
- N_CAPTURE=20, DEPTH=16, i_rd_ready=0 → 16 stored, 4 dropped, o_overflow=1, o_full=1. Then drain 16 pops → o_state returns 00.
- N_CAPTURE=20, i_rd_ready=1 throughout → 20 records read in order, o_overflow=0, o_count never exceeds 1.
- i_h1=i_h2=1 for 70000 cycles → both counters 0xFFFF. Then i_clr_cnt with i_h1=1 in the same cycle → counters 0 next cycle.
- With TRACE_TIMESTAMP_EN: arm, trigger 3 cycles after the arm edge → record 0 timestamp=3, consecutive records +1.
